// File: rtl/fault_campaign_ctrl.sv
// Batch fault-injection campaign controller: golden pass, then one LFSR-stimulated pass per fault ID.
// Each pass is compacted by a MISR; results leave over a valid/ready handshake.
module fault_campaign_ctrl #(
  parameter int               IN_W      = 64,
  parameter int               OBS_W     = 32,
  parameter int               FID_W     = 16,
  parameter int               STEPS_W   = 10,
  parameter logic [IN_W-1:0]  LFSR_POLY = 64'hD800000000000000,
  parameter logic [IN_W-1:0]  LFSR_SEED = 64'h1,
  parameter logic [OBS_W-1:0] MISR_POLY = 32'h04C11DB7,
  parameter logic [IN_W-1:0]  CORE_MASK = 64'h00000FFFFFF00000,
  parameter logic [IN_W-1:0]  AUX_MASK  = 64'h000FF000000FF000,
  parameter int               CORE_DIV  = 2,
  parameter int               AUX_DIV   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FID_W-1:0]   batch_start,
  input  logic [FID_W-1:0]   batch_end,
  input  logic [STEPS_W-1:0] num_steps,
  output logic [IN_W-1:0]    dut_in,
  input  logic [OBS_W-1:0]   dut_obs,
  output logic               fault_en,
  output logic [FID_W-1:0]   fault_id,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [FID_W-1:0]   res_fid,
  output logic               res_detected,
  output logic [OBS_W-1:0]   res_sig,
  output logic [OBS_W-1:0]   golden_sig,
  output logic [FID_W:0]     det_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, APPLY, CAPTURE, REPORT, FIN} state_t;

  localparam logic [STEPS_W-1:0] CORE_M = STEPS_W'(CORE_DIV - 1);
  localparam logic [STEPS_W-1:0] AUX_M  = STEPS_W'(AUX_DIV - 1);

  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

  function automatic logic [OBS_W-1:0] misr_step(input logic [OBS_W-1:0] m,
                                                 input logic [OBS_W-1:0] d);
    return {m[OBS_W-2:0], 1'b0} ^ (m[OBS_W-1] ? MISR_POLY : '0) ^ d;
  endfunction

  state_t             state, state_nx;
  logic [FID_W-1:0]   b_start, b_end;
  logic [STEPS_W-1:0] n_steps, step;
  logic [IN_W-1:0]    lfsr;
  logic [OBS_W-1:0]   misr;

  logic               start_c, abort_c, apply_c, cap_c, end_c, hs_c, step_inc_c, pass_c;
  logic               more_steps, empty, fid_last;
  logic [STEPS_W:0]   step_p1;
  logic [FID_W-1:0]   fid_inc;
  logic [IN_W-1:0]    upd_mask;
  logic [OBS_W-1:0]   misr_nx, sig_end;

  assign step_p1    = {1'b0, step} + (STEPS_W+1)'(1);
  assign more_steps = step_p1 < {1'b0, n_steps};
  assign empty      = (b_end <= b_start);
  assign fid_inc    = fault_id + FID_W'(1);
  assign fid_last   = (fid_inc == b_end);
  assign misr_nx    = misr_step(misr, dut_obs);
  // A zero-step pass ends straight from APPLY with the cleared signature.
  assign sig_end    = (state == CAPTURE) ? misr_nx : misr;
  // Overlapping bits belong to the CORE group, so AUX never touches them.
  assign upd_mask   = (((step & CORE_M) == '0) ? CORE_MASK : '0)
                    | (((step & AUX_M) == '0) ? (AUX_MASK & ~CORE_MASK) : '0);

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_c    = 1'b0;
    abort_c    = 1'b0;
    apply_c    = 1'b0;
    cap_c      = 1'b0;
    end_c      = 1'b0;
    hs_c       = 1'b0;
    step_inc_c = 1'b0;
    case (state)
      IDLE:    if (start && !abort) begin start_c = 1'b1; state_nx = APPLY; end
      APPLY:   if (n_steps == '0) end_c = 1'b1;
               else begin apply_c = 1'b1; state_nx = CAPTURE; end
      CAPTURE: begin
        cap_c = 1'b1;
        if (more_steps) begin step_inc_c = 1'b1; state_nx = APPLY; end
        else end_c = 1'b1;
      end
      REPORT:  if (res_ready) begin hs_c = 1'b1; state_nx = fid_last ? FIN : APPLY; end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (end_c) state_nx = fault_en ? REPORT : (empty ? FIN : APPLY);
    // Abort outranks every other event, including a pending handshake.
    if (abort && state != IDLE) begin
      abort_c    = 1'b1;
      state_nx   = IDLE;
      apply_c    = 1'b0;
      cap_c      = 1'b0;
      end_c      = 1'b0;
      hs_c       = 1'b0;
      step_inc_c = 1'b0;
    end
    pass_c = start_c | (end_c & ~fault_en & ~empty) | (hs_c & ~fid_last);
  end

  // Externally visible state: cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in       <= '0;
      fault_en     <= 1'b0;
      fault_id     <= '0;
      res_valid    <= 1'b0;
      res_fid      <= '0;
      res_detected <= 1'b0;
      res_sig      <= '0;
      golden_sig   <= '0;
      det_count    <= '0;
    end else if (abort_c) begin
      dut_in    <= '0;
      fault_en  <= 1'b0;
      fault_id  <= '0;
      res_valid <= 1'b0;
    end else begin
      if (start_c) begin
        det_count  <= '0;
        golden_sig <= '0;
        fault_en   <= 1'b0;
        fault_id   <= '0;
      end
      if (apply_c) dut_in <= (dut_in & ~upd_mask) | (lfsr & upd_mask);
      if (end_c && !fault_en) begin
        golden_sig <= sig_end;
        if (!empty) begin
          fault_en <= 1'b1;
          fault_id <= b_start;
        end
      end
      if (end_c && fault_en) begin
        res_valid    <= 1'b1;
        res_fid      <= fault_id;
        res_sig      <= sig_end;
        res_detected <= (sig_end != golden_sig);
      end
      if (hs_c) begin
        res_valid <= 1'b0;
        det_count <= det_count + {{FID_W{1'b0}}, res_detected};
        if (!fid_last) fault_id <= fid_inc;
      end
      if (state == FIN) begin
        dut_in   <= '0;
        fault_en <= 1'b0;
        fault_id <= '0;
      end
    end
  end

  // Stimulus/compaction datapath: every field is reloaded before use.
  always_ff @(posedge clk) begin
    if (start_c) begin
      b_start <= batch_start;
      b_end   <= batch_end;
      n_steps <= num_steps;
    end
    if (pass_c) begin
      lfsr <= LFSR_SEED;
      misr <= '0;
      step <= '0;
    end else begin
      if (apply_c)    lfsr <= lfsr_step(lfsr);
      if (cap_c)      misr <= misr_nx;
      if (step_inc_c) step <= step_p1[STEPS_W-1:0];
    end
  end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl on an 8-bit identity DUT with stuck-at-0 faults on bits 0..7.
// Fault IDs 8 and above have no effect on the DUT.
module tb_fault_campaign_ctrl;

  localparam int FID_W   = 16;
  localparam int STEPS_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [FID_W-1:0]  batch_start = '0;
  logic [FID_W-1:0]  batch_end = '0;
  logic [STEPS_W-1:0] num_steps = '0;
  logic [7:0]        dut_in;
  logic [7:0]        dut_obs;
  logic              fault_en;
  logic [FID_W-1:0]  fault_id;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [FID_W-1:0]  res_fid;
  logic              res_detected;
  logic [7:0]        res_sig;
  logic [7:0]        golden_sig;
  logic [FID_W:0]    det_count;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_err    = 0;
  int n        = 0;

  always #5 clk = ~clk;

  always_comb begin
    dut_obs = dut_in;
    if (fault_en && fault_id < 16'd8) dut_obs[fault_id[2:0]] = 1'b0;
  end

  fault_campaign_ctrl #(
    .IN_W(8), .OBS_W(8), .FID_W(FID_W), .STEPS_W(STEPS_W),
    .LFSR_POLY(8'hB8), .LFSR_SEED(8'hFF), .MISR_POLY(8'h07),
    .CORE_MASK(8'h0F), .AUX_MASK(8'hF0), .CORE_DIV(2), .AUX_DIV(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .batch_start(batch_start), .batch_end(batch_end), .num_steps(num_steps),
    .dut_in(dut_in), .dut_obs(dut_obs), .fault_en(fault_en), .fault_id(fault_id),
    .res_valid(res_valid), .res_ready(res_ready), .res_fid(res_fid),
    .res_detected(res_detected), .res_sig(res_sig), .golden_sig(golden_sig),
    .det_count(det_count), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic logic [7:0] m_lfsr(input logic [7:0] l);
    return l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
  endfunction

  // Stimulus value held on dut_in after step s has been applied.
  function automatic logic [7:0] m_din(input int s);
    logic [7:0] l = 8'hFF;
    logic [7:0] d = 8'h00;
    for (int i = 0; i <= s; i++) begin
      if (i % 2 == 0) d[3:0] = l[3:0];
      if (i % 8 == 0) d[7:4] = l[7:4];
      l = m_lfsr(l);
    end
    return d;
  endfunction

  // Signature of a pass; fid < 0 means fault-free.
  function automatic logic [7:0] m_sig(input int steps, input int fid);
    logic [7:0] m = 8'h00;
    logic [7:0] o;
    for (int i = 0; i < steps; i++) begin
      o = m_din(i);
      if (fid >= 0 && fid < 8) o[fid] = 1'b0;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h07 : 8'h00) ^ o;
    end
    return m;
  endfunction

  task automatic launch(input int bs, input int be, input int ns);
    batch_start = FID_W'(bs);
    batch_end   = FID_W'(be);
    num_steps   = STEPS_W'(ns);
    start = 1'b1;
    n = 0;
    tick();
    start = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] gold;
    int         results;
    int         guard;
    int         exp_cnt;
    bit         seen;

    gold = m_sig(16, -1);

    // Reset state
    #3;
    chk("rst_dut_in", 64'(dut_in), 64'h0);
    chk("rst_ctrl", {59'h0, fault_en, res_valid, res_detected, busy, done}, 64'h0);
    chk("rst_ids", {32'h0, fault_id, res_fid}, 64'h0);
    chk("rst_sigs", {40'h0, res_sig, golden_sig, 7'h0, det_count}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic campaign with stimulus-pattern checks
    launch(0, 8, 16);
    chk("a_busy", 64'(busy), 64'h1);
    chk("a_golden_fen", 64'(fault_en), 64'h0);
    for (int s = 0; s < 16; s++) begin
      tick();
      chk($sformatf("a_gold_din_s%0d", s), 64'(dut_in), 64'(m_din(s)));
      if (s == 0) chk("a_din_s0_hand", 64'(dut_in), 64'hFF);
      if (s == 2) chk("a_din_s2_hand", 64'(dut_in), 64'hFB);
      if (s == 4) chk("a_din_s4_hand", 64'(dut_in), 64'hF2);
      if (s == 6) chk("a_din_s6_hand", 64'(dut_in), 64'hFC);
      if (s == 8) chk("a_din_s8_hand", 64'(dut_in), 64'h23);
      tick();
    end
    chk("a_first_fen", 64'(fault_en), 64'h1);
    chk("a_first_fid", 64'(fault_id), 64'h0);
    chk("a_golden_sig", 64'(golden_sig), 64'(gold));
    for (int s = 0; s < 16; s++) begin
      tick();
      chk($sformatf("a_f0_din_s%0d", s), 64'(dut_in), 64'(m_din(s)));
      tick();
    end
    results = 0;
    guard = 0;
    while (!done && guard < 600) begin
      if (res_valid) begin
        chk($sformatf("a_res_fid%0d", results), 64'(res_fid), 64'(results));
        chk($sformatf("a_res_sig%0d", results), 64'(res_sig), 64'(m_sig(16, results)));
        chk($sformatf("a_res_det%0d", results), 64'(res_detected),
            64'(m_sig(16, results) != gold));
        results++;
      end
      tick();
      guard++;
    end
    exp_cnt = 0;
    for (int k = 0; k < 8; k++) if (m_sig(16, k) != gold) exp_cnt++;
    chk("a_done", 64'(done), 64'h1);
    chk("a_latency", 64'(n), 64'(32 + 8 * 33 + 1));
    chk("a_results", 64'(results), 64'd8);
    chk("a_det_count", 64'(det_count), 64'(exp_cnt));
    tick();
    chk("a_after_fin", {60'h0, busy, done, fault_en, 1'b0}, 64'h0);
    chk("a_after_fin_din", 64'(dut_in), 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("a_single_done", 64'(seen), 64'h0);
    chk("a_det_hold", 64'(det_count), 64'(exp_cnt));

    // Benign fault
    launch(9, 10, 16);
    chk("b_det_cleared", 64'(det_count), 64'h0);
    guard = 0;
    while (!res_valid && guard < 200) begin tick(); guard++; end
    chk("b_res_valid", 64'(res_valid), 64'h1);
    chk("b_res_fid", 64'(res_fid), 64'd9);
    chk("b_res_det", 64'(res_detected), 64'h0);
    chk("b_res_sig", 64'(res_sig), 64'(gold));
    guard = 0;
    while (!done && guard < 50) begin tick(); guard++; end
    chk("b_done", 64'(done), 64'h1);
    chk("b_det_count", 64'(det_count), 64'h0);
    tick();

    // Backpressure
    res_ready = 1'b0;
    launch(2, 4, 16);
    guard = 0;
    while (!res_valid && guard < 200) begin tick(); guard++; end
    chk("c_res_valid", 64'(res_valid), 64'h1);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("c_hold%0d", i),
          {res_valid, 7'h0, res_sig, res_fid, fault_id, dut_in},
          {1'b1, 7'h0, m_sig(16, 2), 16'd2, 16'd2, m_din(15)});
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("c_resume_valid", 64'(res_valid), 64'h0);
    chk("c_resume_fid", 64'(fault_id), 64'd3);
    guard = 0;
    while (!done && guard < 200) begin tick(); guard++; end
    chk("c_done", 64'(done), 64'h1);
    chk("c_det_count", 64'(det_count),
        64'((m_sig(16, 2) != gold) + (m_sig(16, 3) != gold)));
    tick();

    // Empty batch: golden pass only
    launch(5, 5, 16);
    seen = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin
      if (res_valid) seen = 1'b1;
      tick();
      guard++;
    end
    chk("d_done", 64'(done), 64'h1);
    chk("d_latency", 64'(n), 64'd33);
    chk("d_no_result", 64'(seen), 64'h0);
    chk("d_det_count", 64'(det_count), 64'h0);
    chk("d_golden", 64'(golden_sig), 64'(gold));
    tick();

    // Zero steps: empty signatures, nothing detected
    launch(0, 3, 0);
    results = 0;
    guard = 0;
    while (!done && guard < 100) begin
      if (res_valid) begin
        chk($sformatf("e_res_fid%0d", results), 64'(res_fid), 64'(results));
        chk($sformatf("e_res_det%0d", results), 64'(res_detected), 64'h0);
        chk($sformatf("e_res_sig%0d", results), 64'(res_sig), 64'h0);
        results++;
      end
      tick();
      guard++;
    end
    chk("e_done", 64'(done), 64'h1);
    chk("e_results", 64'(results), 64'd3);
    chk("e_golden", 64'(golden_sig), 64'h0);
    chk("e_det_count", 64'(det_count), 64'h0);
    tick();

    // Abort mid-campaign
    launch(0, 8, 16);
    while (n < 40) tick();
    chk("f_busy_pre", 64'(busy), 64'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("f_abort_ctrl", {60'h0, busy, done, fault_en, res_valid}, 64'h0);
    chk("f_abort_din", 64'(dut_in), 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("f_stay_idle", 64'(seen), 64'h0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("f_start_abort_idle", 64'(busy), 64'h0);

    // Asynchronous reset while a result is pending
    res_ready = 1'b0;
    launch(3, 5, 4);
    guard = 0;
    while (!res_valid && guard < 100) begin tick(); guard++; end
    chk("g_res_valid", 64'(res_valid), 64'h1);
    chk("g_res_fid", 64'(res_fid), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("g_rst_ctrl", {60'h0, busy, done, fault_en, res_valid}, 64'h0);
    chk("g_rst_ids", {32'h0, fault_id, res_fid}, 64'h0);
    chk("g_rst_data", {32'h0, res_sig, golden_sig, dut_in, 7'h0, res_detected}, 64'h0);
    chk("g_rst_det", 64'(det_count), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
